ledscan: RTL

Downstream consumer of the pattern generator: accepts pixel writes (`addr`/`rgb`/`write`) and the `display` frame toggle into a double-buffered 32x16 RGB frame store, then scans the read bank onto a HUB75-style 1/8-scan LED panel. Brightness uses binary-coded modulation (BCM) over `BITS` bit planes. Buffers swap only at a frame boundary, so the panel never shows a partly written frame.

---
 rtl/ledscan.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ledscan.sv
// rtl/ledscan.sv - double-buffered 32x16 RGB frame store scanned onto a 1/8-scan HUB75 panel with BCM
// Optional LEDSCAN_GAMMA_EN squares each channel on write for an approximate gamma of 2.
module ledscan #(
  parameter int BITS    = 4,
  parameter int BASE_ON = 1
) (
  input  logic        i_pixclk,
  input  logic        i_reset_n,
  input  logic [8:0]  i_addr,
  input  logic [23:0] i_rgb,
  input  logic        i_write,
  input  logic        i_display,
  output logic        o_r0,
  output logic        o_g0,
  output logic        o_b0,
  output logic        o_r1,
  output logic        o_g1,
  output logic        o_b1,
  output logic [2:0]  o_panel_a,
  output logic        o_panel_clk,
  output logic        o_panel_lat,
  output logic        o_panel_oe_n,
  output logic        o_vsync
);

  localparam int MAXDUR = BASE_ON << (BITS - 1);
  localparam int CW     = $clog2(MAXDUR + 1);

  typedef enum logic [1:0] {SHIFT, LATCH, SHOW} state_t;

  // Index is {bank, row[2:0], col}; the two halves let rows r and r+8 be read together.
  logic [23:0] r_mem_up [0:511];
  logic [23:0] r_mem_lo [0:511];

  state_t      r_state;
  logic [6:0]  r_k;
  logic [2:0]  r_row;
  logic [2:0]  r_plane;
  logic [CW-1:0] r_cnt;
  logic        r_rd_bank;
  logic        r_swap_pending;
  logic        r_disp_s1;
  logic        r_disp_s2;
  logic        r_disp_d;
  logic        r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;
  logic [2:0]  r_panel_a;
  logic        r_pclk;
  logic        r_lat;
  logic        r_oe_n;
  logic        r_vsync;

  logic [23:0] w_wdata;
  logic [8:0]  w_widx;
  logic [8:0]  w_ridx;
  logic [4:0]  w_sel_b;
  logic [4:0]  w_sel_g;
  logic [4:0]  w_sel_r;
  logic [CW-1:0] w_dur;
  logic        w_last;
  logic        w_edge;

`ifdef LEDSCAN_GAMMA_EN
  function automatic logic [7:0] gamma8(input logic [7:0] c);
    logic [15:0] sq;
    sq = c * c;
    return sq[15:8];
  endfunction

  assign w_wdata = {gamma8(i_rgb[23:16]), gamma8(i_rgb[15:8]), gamma8(i_rgb[7:0])};
`else
  assign w_wdata = i_rgb;
`endif

  assign w_widx  = {~r_rd_bank, i_addr[7:5], i_addr[4:0]};
  assign w_ridx  = {r_rd_bank, r_row, r_k[5:1]};
  assign w_sel_b = 5'(8 - BITS) + {2'b00, r_plane};
  assign w_sel_g = w_sel_b + 5'd8;
  assign w_sel_r = w_sel_b + 5'd16;
  assign w_dur   = CW'(BASE_ON << r_plane);
  assign w_last  = (r_row == 3'd7) && (r_plane == 3'(BITS - 1));
  assign w_edge  = r_disp_s2 ^ r_disp_d;

  always_ff @(posedge i_pixclk) begin
    if (i_write) begin
      if (i_addr[8]) r_mem_lo[w_widx] <= w_wdata;
      else           r_mem_up[w_widx] <= w_wdata;
    end
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= SHIFT;
      r_k            <= '0;
      r_row          <= '0;
      r_plane        <= '0;
      r_cnt          <= '0;
      r_rd_bank      <= 1'b0;
      r_swap_pending <= 1'b0;
      r_disp_s1      <= 1'b0;
      r_disp_s2      <= 1'b0;
      r_disp_d       <= 1'b0;
      {r_r0, r_g0, r_b0, r_r1, r_g1, r_b1} <= '0;
      r_panel_a      <= '0;
      r_pclk         <= 1'b0;
      r_lat          <= 1'b0;
      r_oe_n         <= 1'b1;
      r_vsync        <= 1'b0;
    end else begin
      r_disp_s1 <= i_display;
      r_disp_s2 <= r_disp_s1;
      r_disp_d  <= r_disp_s2;
      if (w_edge) r_swap_pending <= 1'b1;
      r_vsync <= 1'b0;
      r_lat   <= 1'b0;
      r_pclk  <= 1'b0;
      case (r_state)
        SHIFT: begin
          // Column c is fetched at k=2c and held through k=2c+2, where the panel clocks it in.
          r_pclk <= r_k[0];
          if (r_k == 7'd64) begin
            {r_r0, r_g0, r_b0, r_r1, r_g1, r_b1} <= '0;
            r_k       <= '0;
            r_lat     <= 1'b1;
            r_panel_a <= r_row;
            r_state   <= LATCH;
          end else begin
            if (!r_k[0]) begin
              r_r0 <= r_mem_up[w_ridx][w_sel_r];
              r_g0 <= r_mem_up[w_ridx][w_sel_g];
              r_b0 <= r_mem_up[w_ridx][w_sel_b];
              r_r1 <= r_mem_lo[w_ridx][w_sel_r];
              r_g1 <= r_mem_lo[w_ridx][w_sel_g];
              r_b1 <= r_mem_lo[w_ridx][w_sel_b];
            end
            r_k <= r_k + 7'd1;
          end
        end
        LATCH: begin
          r_oe_n  <= 1'b0;
          r_cnt   <= w_dur - CW'(1);
          r_vsync <= w_last && (w_dur == CW'(1));
          r_state <= SHOW;
        end
        SHOW: begin
          if (r_cnt == '0) begin
            r_oe_n  <= 1'b1;
            r_state <= SHIFT;
            if (r_plane == 3'(BITS - 1)) begin
              r_plane <= '0;
              r_row   <= r_row + 3'd1;
            end else begin
              r_plane <= r_plane + 3'd1;
            end
            // A swap request arriving in the frame-end cycle itself is honoured here too.
            if (w_last && (r_swap_pending || w_edge)) begin
              r_rd_bank      <= ~r_rd_bank;
              r_swap_pending <= 1'b0;
            end
          end else begin
            r_cnt   <= r_cnt - CW'(1);
            r_vsync <= w_last && (r_cnt == CW'(1));
          end
        end
        default: r_state <= SHIFT;
      endcase
    end
  end

  assign o_r0         = r_r0;
  assign o_g0         = r_g0;
  assign o_b0         = r_b0;
  assign o_r1         = r_r1;
  assign o_g1         = r_g1;
  assign o_b1         = r_b1;
  assign o_panel_a    = r_panel_a;
  assign o_panel_clk  = r_pclk;
  assign o_panel_lat  = r_lat;
  assign o_panel_oe_n = r_oe_n;
  assign o_vsync      = r_vsync;

endmodule
